// File: rtl/uart_tx_param.sv
// uart_tx_param
//
// Parametrised UART transmitter. Words come in over a valid/ready handshake,
// are queued in a small circular FIFO and are serialised LSB-first. Frame
// format (5..9 data bits, none/odd/even parity, 1 or 2 stop bits), baud rate
// and FIFO depth are fixed at elaboration time.
//
// Ports:
//   clk              system clock (CLK_FREQ Hz)
//   reset            synchronous, active-high reset
//   i_tx_data        word to send, DATA_BITS wide
//   i_tx_data_valid  word presented this cycle
//   i_tx_break       (only with UART_TX_BREAK_EN) hold the line low between frames
//   o_tx_ready       FIFO can accept a word (not full)
//   o_tx_serial      serial line, idle high
//   o_tx_busy        frame in progress or FIFO non-empty
//   o_fifo_count     number of queued words
//
// Optional feature macro: UART_TX_BREAK_EN
//   When defined, adds i_tx_break. A break is only started between frames,
//   and after it is released the line is held at mark for one full stop
//   period before the next start bit.

module uart_tx_param #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          i_tx_data,
    input  logic                          i_tx_data_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                          i_tx_break,
`endif
    output logic                          o_tx_ready,
    output logic                          o_tx_serial,
    output logic                          o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] LAST_BAUD  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP  = BIT_W'(STOP_BITS - 1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic [2:0]           state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;

    logic                 brk;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic [DATA_BITS-1:0] head;

`ifdef UART_TX_BREAK_EN
    assign brk = i_tx_break;
`else
    assign brk = 1'b0;
`endif

    // Ready depends only on the registered count, so a pop on the same edge
    // never frees a slot for a push while full.
    assign push    = i_tx_data_valid && (count != FULL_COUNT);
    assign bit_end = (baud_cnt == LAST_BAUD);
    assign head    = mem[rd_ptr];

    // A pop happens when the line is free: from IDLE, or on the last cycle of
    // the final stop bit so that back-to-back frames have no idle gap. A
    // pending break wins over the next pop.
    always_comb begin
        pop = 1'b0;
        if ((count != '0) && !brk) begin
            if (state == S_IDLE) begin
                pop = 1'b1;
            end else if ((state == S_STOP) && bit_end && (bit_idx == LAST_STOP)) begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_tx_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer. bit_idx counts data bits in DATA and stop bits in STOP.
    // The parity bit is computed from the whole word when it is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (brk) begin
                        state <= S_BREAK;
                    end else if (pop) begin
                        shift_reg  <= head;
                        parity_bit <= (PARITY == 1) ? ~(^head) : (^head);
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            if (brk) begin
                                state <= S_BREAK;
                            end else if (pop) begin
                                shift_reg  <= head;
                                parity_bit <= (PARITY == 1) ? ~(^head) : (^head);
                                state      <= S_START;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Releasing the break re-enters STOP from its start, which
                    // guarantees a full stop period of mark before the next frame.
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!brk) begin
                        state <= S_STOP;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        case (state)
            S_START:  o_tx_serial = 1'b0;
            S_DATA:   o_tx_serial = shift_reg[0];
            S_PARITY: o_tx_serial = parity_bit;
            S_BREAK:  o_tx_serial = 1'b0;
            default:  o_tx_serial = 1'b1;
        endcase
    end

    assign o_tx_ready   = (count != FULL_COUNT);
    assign o_tx_busy    = (state != S_IDLE) || (count != '0);
    assign o_fifo_count = count;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
//
// Directed bench for uart_tx_param. Three instances cover different frame
// formats at 12 clk/bit:
//   dut1: 8N1, FIFO depth 4
//   dut2: 7E2, FIFO depth 2
//   dut3: 8O1, FIFO depth 2
// Outputs are sampled on the falling clock edge; inputs change there too.

module tb_uart_tx_param;

    localparam int CPB = 12;

    logic clk = 1'b0;
    logic reset;

    logic [7:0] data1;
    logic       valid1, ready1, line1, busy1;
    logic [2:0] count1;
`ifdef UART_TX_BREAK_EN
    logic       brk1;
    logic       brk2;
    logic       brk3;
`endif

    logic [6:0] data2;
    logic       valid2, ready2, line2, busy2;
    logic [1:0] count2;

    logic [7:0] data3;
    logic       valid3, ready3, line3, busy3;
    logic [1:0] count3;

    int compares   = 0;
    int mismatches = 0;

    always #5 clk = ~clk;

    uart_tx_param #(
        .CLK_FREQ(12000000), .BAUDRATE(1000000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .reset(reset),
        .i_tx_data(data1), .i_tx_data_valid(valid1),
`ifdef UART_TX_BREAK_EN
        .i_tx_break(brk1),
`endif
        .o_tx_ready(ready1), .o_tx_serial(line1), .o_tx_busy(busy1),
        .o_fifo_count(count1)
    );

    uart_tx_param #(
        .CLK_FREQ(12000000), .BAUDRATE(1000000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)
    ) dut2 (
        .clk(clk), .reset(reset),
        .i_tx_data(data2), .i_tx_data_valid(valid2),
`ifdef UART_TX_BREAK_EN
        .i_tx_break(brk2),
`endif
        .o_tx_ready(ready2), .o_tx_serial(line2), .o_tx_busy(busy2),
        .o_fifo_count(count2)
    );

    uart_tx_param #(
        .CLK_FREQ(12000000), .BAUDRATE(1000000), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)
    ) dut3 (
        .clk(clk), .reset(reset),
        .i_tx_data(data3), .i_tx_data_valid(valid3),
`ifdef UART_TX_BREAK_EN
        .i_tx_break(brk3),
`endif
        .o_tx_ready(ready3), .o_tx_serial(line3), .o_tx_busy(busy3),
        .o_fifo_count(count3)
    );

    function automatic logic lineOf(input int which);
        case (which)
            1:       return line1;
            2:       return line2;
            default: return line3;
        endcase
    endfunction

    function automatic logic busyOf(input int which);
        case (which)
            1:       return busy1;
            2:       return busy2;
            default: return busy3;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compares++;
        assert (observed === expected) else begin
            mismatches++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one word for exactly one rising edge E; returns at the falling
    // edge right after E.
    task automatic applyStimulus(input int which, input logic [8:0] value);
        @(negedge clk);
        case (which)
            1:       begin data1 = value[7:0]; valid1 = 1'b1; end
            2:       begin data2 = value[6:0]; valid2 = 1'b1; end
            default: begin data3 = value[7:0]; valid3 = 1'b1; end
        endcase
        @(negedge clk);
        valid1 = 1'b0;
        valid2 = 1'b0;
        valid3 = 1'b0;
    endtask

    // Called at the falling edge after the accepting edge E. frame[i] is the
    // i-th line bit (start first). Every cycle of the frame is checked.
    task automatic checkFrame(input string tag, input int which,
                              input logic [15:0] frame, input int nbits);
        checkOutput({tag, ".latency"}, 16'(lineOf(which)), 16'h1);
        for (int n = 0; n < nbits * CPB; n++) begin
            @(negedge clk);
            checkOutput($sformatf("%s.bit%0d", tag, n / CPB), 16'(lineOf(which)),
                        16'(frame[n / CPB]));
        end
        checkOutput({tag, ".busy_last"}, 16'(busyOf(which)), 16'h1);
        @(negedge clk);
        checkOutput({tag, ".busy_drop"}, 16'(busyOf(which)), 16'h0);
        checkOutput({tag, ".idle_line"}, 16'(lineOf(which)), 16'h1);
    endtask

    initial begin
        logic [7:0]  byte_val;
        logic [15:0] frame_val;

        reset  = 1'b1;
        data1  = '0; valid1 = 1'b0;
        data2  = '0; valid2 = 1'b0;
        data3  = '0; valid3 = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk1 = 1'b0;
        brk2 = 1'b0;
        brk3 = 1'b0;
`endif
        repeat (3) @(negedge clk);

        checkOutput("reset.line1",  16'(line1),  16'h1);
        checkOutput("reset.busy1",  16'(busy1),  16'h0);
        checkOutput("reset.count1", 16'(count1), 16'h0);
        checkOutput("reset.ready1", 16'(ready1), 16'h1);
        checkOutput("reset.line2",  16'(line2),  16'h1);
        checkOutput("reset.line3",  16'(line3),  16'h1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0x55: 10 bits, 120 cycles
        applyStimulus(1, 9'h055);
        checkFrame("t1_8n1_55", 1, {6'b0, 1'b1, 8'h55, 1'b0}, 10);

        // 7E2 0x07: three ones -> even parity bit 1; 11 bits, 132 cycles
        applyStimulus(2, 9'h007);
        checkFrame("t2_7e2_07", 2, {5'b0, 2'b11, 1'b1, 7'h07, 1'b0}, 11);

        // 8O1 0x07: three ones -> odd parity bit 0; 11 bits, 132 cycles
        applyStimulus(3, 9'h007);
        checkFrame("t3_8o1_07", 3, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);

        // Depth-4 FIFO, valid held with 0x01..0x06. Word 1 is accepted at E1
        // and starts at E2; n counts falling edges after E2.
        @(negedge clk);
        data1  = 8'h01;
        valid1 = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            data1 = 8'(k);
        end
        @(negedge clk);
        checkOutput("t4.count_full", 16'(count1), 16'h4);
        checkOutput("t4.ready_low",  16'(ready1), 16'h0);
        data1 = 8'h06;
        for (int n = 4; n <= 6 * 10 * CPB; n++) begin
            @(negedge clk);
            if (n < 6 * 10 * CPB) begin
                byte_val  = 8'(n / (10 * CPB) + 1);
                frame_val = {6'b0, 1'b1, byte_val, 1'b0};
                checkOutput($sformatf("t4.stream_n%0d", n), 16'(line1),
                            16'(frame_val[(n % (10 * CPB)) / CPB]));
            end else begin
                checkOutput("t4.busy_end", 16'(busy1), 16'h0);
                checkOutput("t4.line_end", 16'(line1), 16'h1);
            end
            if (n == 60) begin
                checkOutput("t4.push_full_ignored", 16'(count1), 16'h4);
            end
            if (n == 120) begin
                checkOutput("t4.count_after_pop", 16'(count1), 16'h3);
                checkOutput("t4.ready_after_pop", 16'(ready1), 16'h1);
            end
            if (n == 121) begin
                checkOutput("t4.count_refill", 16'(count1), 16'h4);
                valid1 = 1'b0;
            end
        end

        // Reset during data bit 3 of 0xA5 with two words queued
        @(negedge clk);
        data1  = 8'hA5;
        valid1 = 1'b1;
        @(negedge clk);
        data1 = 8'h11;
        @(negedge clk);
        data1 = 8'h22;
        @(negedge clk);
        valid1 = 1'b0;
        checkOutput("t5.count_two", 16'(count1), 16'h2);
        repeat (51) @(negedge clk);
        checkOutput("t5.bit3_low", 16'(line1), 16'h0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5.line",  16'(line1),  16'h1);
        checkOutput("t5.count", 16'(count1), 16'h0);
        checkOutput("t5.busy",  16'(busy1),  16'h0);
        checkOutput("t5.ready", 16'(ready1), 16'h1);
        reset = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            checkOutput("t5.quiet", {14'b0, busy1, line1}, 16'h1);
        end

`ifdef UART_TX_BREAK_EN
        // Break raised mid-frame; n counts falling edges after the start edge.
        applyStimulus(1, 9'h055);
        for (int n = 0; n <= 153; n++) begin
            @(negedge clk);
            if (n == 30) brk1 = 1'b1;
            if (n == 50) begin data1 = 8'h0F; valid1 = 1'b1; end
            if (n == 51) valid1 = 1'b0;
            if (n == 119) checkOutput("t6.stop_completes", 16'(line1), 16'h1);
            if (n >= 120 && n <= 140) checkOutput("t6.break_low", 16'(line1), 16'h0);
            if (n == 140) brk1 = 1'b0;
            if (n >= 141 && n <= 152) checkOutput("t6.mark_after", 16'(line1), 16'h1);
            if (n == 152) checkOutput("t6.count_held", 16'(count1), 16'h1);
            if (n == 153) begin
                checkOutput("t6.start_next", 16'(line1), 16'h0);
                checkOutput("t6.popped", 16'(count1), 16'h0);
            end
        end
        for (int n = 0; n < 200 && busy1; n++) begin
            @(negedge clk);
        end
        checkOutput("t6.idle_timeout", 16'(busy1), 16'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
